main_controller_mc: RTL and testbench

//  Multicycle successor to the single-cycle main decoder: a Moore FSM that sequences each MIPS instruction

---
 rtl/main_controller_mc_if.sv | 43 ++++
 rtl/main_controller_mc.sv | 174 +++++++++++++++++
 tb/tb_main_controller_mc.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_controller_mc_if.sv
// Bus between the multicycle main controller and the datapath/memory side.
//   master : controller view (consumes opcode/mem_ready/zero, drives controls and status)
//   slave  : datapath view (drives opcode/mem_ready/zero, consumes controls and status)
// Signals:
//   opcode        IR[31:26]
//   mem_ready     memory access completes this cycle
//   zero          ALU zero flag
//   IorD .. pc_en datapath enables and selects
//   illegal_op    sticky illegal-opcode flag
//   instr_retired retired-instruction counter
interface main_controller_mc_if #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned CNT_W    = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                zero;
  logic                IorD;
  logic                MemWrite;
  logic                IRWrite;
  logic                RegDst;
  logic                MemToReg;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic [1:0]          PCSrc;
  logic                pc_en;
  logic                illegal_op;
  logic [CNT_W-1:0]    instr_retired;

  modport master (
    input  opcode, mem_ready, zero,
    output IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           PCSrc, pc_en, illegal_op, instr_retired
  );

  modport slave (
    output opcode, mem_ready, zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           PCSrc, pc_en, illegal_op, instr_retired
  );
endinterface

// File: rtl/main_controller_mc.sv
// Multicycle MIPS main controller: Moore FSM sequencing each instruction over 3-5 cycles,
// with memory-ready stalls, optional bne, illegal-opcode trap and retired-instruction counter.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low (also forces all write enables low while asserted)
//   bus    main_controller_mc_if.master: opcode/mem_ready/zero in, datapath controls and
//          illegal_op/instr_retired out
module main_controller_mc #(
  parameter int unsigned OPCODE_W     = 6,
  parameter bit          EN_BNE       = 1'b1,
  parameter bit          TRAP_ILLEGAL = 1'b1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  main_controller_mc_if.master bus
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec,
    StAluWb, StBranch, StAddiEx, StAddiWb, StJump, StIllegal
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic [5:0]       op6;
  logic             retire;
  logic             is_bne;

  // Opcode is compared on 6 bits, zero-extended when narrower.
  if (OPCODE_W >= 6) begin : g_op_wide
    assign op6 = bus.opcode[5:0];
  end else begin : g_op_narrow
    assign op6 = {{(6 - OPCODE_W){1'b0}}, bus.opcode};
  end

  assign is_bne = EN_BNE && (op6 == OpBne);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (op6)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpBne:      state_d = EN_BNE ? StBranch : StIllegal;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StIllegal;
        endcase
      end
      StMemAdr: state_d = (op6 == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (bus.mem_ready) state_d = StMemWb;
      StMemWr:  if (bus.mem_ready) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StBranch, StAddiWb, StJump, StIllegal: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Every completed instruction returns to FETCH; ILLEGAL does too but is not counted.
  always_comb begin
    retire = (state_q inside {StMemWb, StAluWb, StBranch, StAddiWb, StJump}) ||
             ((state_q == StMemWr) && bus.mem_ready);
    cnt_d     = retire ? cnt_q + CNT_W'(1) : cnt_q;
    illegal_d = illegal_q | (TRAP_ILLEGAL && (state_q == StIllegal));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en;
  logic [1:0] alu_src_b, alu_op, pc_src;

  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    if (!rst_n) begin
      // Mid-instruction reset aborts at once: enables drop in this same cycle.
      alu_src_b = 2'b01;
    end else begin
      unique case (state_q)
        StFetch: begin
          alu_src_b = 2'b01;
          ir_write  = bus.mem_ready;
          pc_en     = bus.mem_ready;
        end
        StDecode: alu_src_b = 2'b11;
        StMemAdr: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        StMemRd: iord = 1'b1;
        StMemWb: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        StMemWr: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        StExec: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        StAluWb: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        StBranch: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          pc_en     = is_bne ? ~bus.zero : bus.zero;
        end
        StAddiEx: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        StAddiWb: reg_write = 1'b1;
        StJump: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.IorD          = iord;
  assign bus.MemWrite      = mem_write;
  assign bus.IRWrite       = ir_write;
  assign bus.RegDst        = reg_dst;
  assign bus.MemToReg      = mem_to_reg;
  assign bus.RegWrite      = reg_write;
  assign bus.ALUSrcA       = alu_src_a;
  assign bus.ALUSrcB       = alu_src_b;
  assign bus.ALUOp         = alu_op;
  assign bus.PCSrc         = pc_src;
  assign bus.pc_en         = pc_en;
  assign bus.illegal_op    = illegal_q;
  assign bus.instr_retired = cnt_q;

endmodule

// File: tb/tb_main_controller_mc.sv
// Bench for main_controller_mc: three instances share clock, reset and inputs
//   dut    : EN_BNE=1, TRAP_ILLEGAL=1 (scoreboarded every cycle)
//   dut_nb : EN_BNE=0, TRAP_ILLEGAL=1
//   dut_nt : EN_BNE=1, TRAP_ILLEGAL=0
module tb_main_controller_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  main_controller_mc_if #(.OPCODE_W(6), .CNT_W(32)) bus_m ();
  main_controller_mc_if #(.OPCODE_W(6), .CNT_W(32)) bus_nb ();
  main_controller_mc_if #(.OPCODE_W(6), .CNT_W(32)) bus_nt ();

  main_controller_mc #(.OPCODE_W(6), .EN_BNE(1'b1), .TRAP_ILLEGAL(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_m)
  );
  main_controller_mc #(.OPCODE_W(6), .EN_BNE(1'b0), .TRAP_ILLEGAL(1'b1), .CNT_W(32)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(bus_nb)
  );
  main_controller_mc #(.OPCODE_W(6), .EN_BNE(1'b1), .TRAP_ILLEGAL(1'b0), .CNT_W(32)) dut_nt (
    .clk(clk), .rst_n(rst_n), .bus(bus_nt)
  );

  // Expected-state codes used by the bench.
  localparam logic [3:0] SRst = 4'd0, SFetch = 4'd1, SDecode = 4'd2, SMemAdr = 4'd3,
                         SMemRd = 4'd4, SMemWb = 4'd5, SMemWr = 4'd6, SExec = 4'd7,
                         SAluWb = 4'd8, SBranch = 4'd9, SAddiEx = 4'd10, SAddiWb = 4'd11,
                         SJump = 4'd12, SIllegal = 4'd13;

  typedef struct packed {
    logic [3:0] st;
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic       z;
  } stim_t;

  typedef struct packed {
    logic [13:0] ctl;
    logic [31:0] cnt;
    logic        ill;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] model_cnt = '0;
  logic        model_ill = 1'b0;

  logic [13:0] obs_ctl;
  logic [31:0] obs_cnt, obs_nb_cnt, obs_nt_cnt;
  logic        obs_ill, obs_nb_ill, obs_nt_ill;

  function automatic stim_t mk(input logic [3:0] st, input logic r, input logic [5:0] op,
                               input logic mr, input logic z);
    return {st, r, op, mr, z};
  endfunction

  // {IorD,MemWrite,IRWrite,RegDst,MemToReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,pc_en}
  function automatic logic [13:0] ctl_of(input logic [3:0] st, input logic mr, input logic z,
                                         input logic bne);
    logic iord, mw, irw, rd, m2r, rw, asa, pce;
    logic [1:0] asb, aop, pcs;
    {iord, mw, irw, rd, m2r, rw, asa, pce} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      SRst:    asb = 2'b01;
      SFetch:  begin asb = 2'b01; irw = mr; pce = mr; end
      SDecode: asb = 2'b11;
      SMemAdr: begin asa = 1'b1; asb = 2'b10; end
      SMemRd:  iord = 1'b1;
      SMemWb:  begin m2r = 1'b1; rw = 1'b1; end
      SMemWr:  begin iord = 1'b1; mw = 1'b1; end
      SExec:   begin asa = 1'b1; aop = 2'b10; end
      SAluWb:  begin rd = 1'b1; rw = 1'b1; end
      SBranch: begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; pce = bne ? ~z : z; end
      SAddiEx: begin asa = 1'b1; asb = 2'b10; end
      SAddiWb: rw = 1'b1;
      SJump:   begin pcs = 2'b10; pce = 1'b1; end
      default: ;
    endcase
    return {iord, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pce};
  endfunction

  // Drive one cycle of stimulus, push its expectation, sample at the falling edge.
  task automatic drive(input stim_t s);
    exp_t x;
    rst_n = s.rst;
    bus_m.opcode = s.op;  bus_m.mem_ready = s.mr;  bus_m.zero = s.z;
    bus_nb.opcode = s.op; bus_nb.mem_ready = s.mr; bus_nb.zero = s.z;
    bus_nt.opcode = s.op; bus_nt.mem_ready = s.mr; bus_nt.zero = s.z;
    x.ctl = ctl_of(s.st, s.mr, s.z, s.op == 6'b000101);
    x.cnt = model_cnt;
    x.ill = model_ill;
    sb_q.push_back(x);
    @(negedge clk);
    obs_ctl = {bus_m.IorD, bus_m.MemWrite, bus_m.IRWrite, bus_m.RegDst, bus_m.MemToReg,
               bus_m.RegWrite, bus_m.ALUSrcA, bus_m.ALUSrcB, bus_m.ALUOp, bus_m.PCSrc,
               bus_m.pc_en};
    obs_cnt    = bus_m.instr_retired;
    obs_ill    = bus_m.illegal_op;
    obs_nb_cnt = bus_nb.instr_retired;
    obs_nb_ill = bus_nb.illegal_op;
    obs_nt_cnt = bus_nt.instr_retired;
    obs_nt_ill = bus_nt.illegal_op;
  endtask

  // Update the bench model for the edge that closes this cycle, then cross it.
  task automatic advance(input stim_t s);
    if (!s.rst) begin
      model_cnt = '0;
      model_ill = 1'b0;
    end else begin
      if ((s.st inside {SMemWb, SAluWb, SBranch, SAddiWb, SJump}) || (s.st == SMemWr && s.mr))
        model_cnt = model_cnt + 32'd1;
      if (s.st == SIllegal) model_ill = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    stim_t s;
    s = mk(SRst, 1'b0, 6'h00, 1'b0, 1'b0);
    drive(s);
    void'(sb_q.pop_front());
    advance(s);
  endtask

  task automatic test_reset();
    stim_t seq[$];
    seq = '{mk(SRst, 1'b0, 6'h00, 1'b1, 1'b0), mk(SRst, 1'b0, 6'h23, 1'b1, 1'b1),
            mk(SFetch, 1'b1, 6'h3f, 1'b0, 1'b0), mk(SFetch, 1'b1, 6'h3f, 1'b1, 1'b0)};
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({obs_ctl, obs_cnt, obs_ill} !== {e.ctl, e.cnt, e.ill}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got ctl=%b cnt=%0d ill=%b, want ctl=%b cnt=%0d ill=%b",
                 i, obs_ctl, obs_cnt, obs_ill, e.ctl, e.cnt, e.ill);
      end
      advance(seq[i]);
    end
    n_cmp++;
    if ({obs_nb_cnt, obs_nb_ill, obs_nt_cnt, obs_nt_ill} !== {32'd0, 1'b0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_alt: got nb cnt=%0d ill=%b nt cnt=%0d ill=%b, want all 0",
               obs_nb_cnt, obs_nb_ill, obs_nt_cnt, obs_nt_ill);
    end
  endtask

  task automatic test_add();
    stim_t seq[$];
    apply_reset();
    seq = '{mk(SFetch, 1'b1, 6'h3f, 1'b1, 1'b0), mk(SDecode, 1'b1, 6'h00, 1'b0, 1'b0),
            mk(SExec, 1'b1, 6'h00, 1'b0, 1'b1), mk(SAluWb, 1'b1, 6'h23, 1'b0, 1'b0),
            mk(SFetch, 1'b1, 6'h00, 1'b0, 1'b0)};
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({obs_ctl, obs_cnt, obs_ill} !== {e.ctl, e.cnt, e.ill}) begin
        n_fail++;
        $display("FAIL add[%0d]: got ctl=%b cnt=%0d ill=%b, want ctl=%b cnt=%0d ill=%b",
                 i, obs_ctl, obs_cnt, obs_ill, e.ctl, e.cnt, e.ill);
      end
      advance(seq[i]);
    end
  endtask

  task automatic test_lw_stall();
    stim_t seq[$];
    apply_reset();
    // Opcode changes during MEMRD must not matter.
    seq = '{mk(SFetch, 1'b1, 6'h3f, 1'b0, 1'b0), mk(SFetch, 1'b1, 6'h3f, 1'b1, 1'b0),
            mk(SDecode, 1'b1, 6'h23, 1'b0, 1'b0), mk(SMemAdr, 1'b1, 6'h23, 1'b0, 1'b0),
            mk(SMemRd, 1'b1, 6'h2b, 1'b0, 1'b0), mk(SMemRd, 1'b1, 6'h00, 1'b0, 1'b1),
            mk(SMemRd, 1'b1, 6'h3f, 1'b0, 1'b0), mk(SMemRd, 1'b1, 6'h23, 1'b1, 1'b0),
            mk(SMemWb, 1'b1, 6'h02, 1'b1, 1'b0), mk(SFetch, 1'b1, 6'h23, 1'b0, 1'b0)};
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({obs_ctl, obs_cnt, obs_ill} !== {e.ctl, e.cnt, e.ill}) begin
        n_fail++;
        $display("FAIL lw[%0d]: got ctl=%b cnt=%0d ill=%b, want ctl=%b cnt=%0d ill=%b",
                 i, obs_ctl, obs_cnt, obs_ill, e.ctl, e.cnt, e.ill);
      end
      advance(seq[i]);
    end
  endtask

  task automatic test_branch();
    stim_t seq[$];
    apply_reset();
    seq = '{mk(SFetch, 1'b1, 6'h00, 1'b1, 1'b0), mk(SDecode, 1'b1, 6'h04, 1'b0, 1'b1),
            mk(SBranch, 1'b1, 6'h04, 1'b0, 1'b1), mk(SFetch, 1'b1, 6'h00, 1'b1, 1'b0),
            mk(SDecode, 1'b1, 6'h05, 1'b0, 1'b1), mk(SBranch, 1'b1, 6'h05, 1'b0, 1'b1),
            mk(SFetch, 1'b1, 6'h00, 1'b0, 1'b0)};
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({obs_ctl, obs_cnt, obs_ill} !== {e.ctl, e.cnt, e.ill}) begin
        n_fail++;
        $display("FAIL branch[%0d]: got ctl=%b cnt=%0d ill=%b, want ctl=%b cnt=%0d ill=%b",
                 i, obs_ctl, obs_cnt, obs_ill, e.ctl, e.cnt, e.ill);
      end
      advance(seq[i]);
    end
    // Without bne support the second branch traps and is not counted.
    n_cmp++;
    if ({obs_nb_cnt, obs_nb_ill} !== {32'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL bne_disabled: got cnt=%0d ill=%b, want cnt=1 ill=1", obs_nb_cnt, obs_nb_ill);
    end
  endtask

  task automatic test_illegal();
    stim_t seq[$];
    apply_reset();
    seq = '{mk(SFetch, 1'b1, 6'h3f, 1'b1, 1'b0), mk(SDecode, 1'b1, 6'h3f, 1'b0, 1'b0),
            mk(SIllegal, 1'b1, 6'h3f, 1'b1, 1'b0), mk(SFetch, 1'b1, 6'h3f, 1'b1, 1'b0),
            mk(SDecode, 1'b1, 6'h02, 1'b0, 1'b0), mk(SJump, 1'b1, 6'h3f, 1'b0, 1'b0),
            mk(SFetch, 1'b1, 6'h3f, 1'b0, 1'b0)};
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({obs_ctl, obs_cnt, obs_ill} !== {e.ctl, e.cnt, e.ill}) begin
        n_fail++;
        $display("FAIL illegal[%0d]: got ctl=%b cnt=%0d ill=%b, want ctl=%b cnt=%0d ill=%b",
                 i, obs_ctl, obs_cnt, obs_ill, e.ctl, e.cnt, e.ill);
      end
      advance(seq[i]);
    end
    n_cmp++;
    if ({obs_nt_cnt, obs_nt_ill} !== {32'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL no_trap: got cnt=%0d ill=%b, want cnt=1 ill=0", obs_nt_cnt, obs_nt_ill);
    end
  endtask

  task automatic test_back_to_back();
    stim_t seq[$];
    apply_reset();
    seq = '{mk(SFetch, 1'b1, 6'h00, 1'b1, 1'b0), mk(SDecode, 1'b1, 6'h08, 1'b0, 1'b0),
            mk(SAddiEx, 1'b1, 6'h08, 1'b0, 1'b0), mk(SAddiWb, 1'b1, 6'h08, 1'b0, 1'b0),
            mk(SFetch, 1'b1, 6'h08, 1'b1, 1'b0), mk(SDecode, 1'b1, 6'h2b, 1'b0, 1'b0),
            mk(SMemAdr, 1'b1, 6'h2b, 1'b0, 1'b0), mk(SMemWr, 1'b1, 6'h2b, 1'b1, 1'b0),
            mk(SFetch, 1'b1, 6'h2b, 1'b1, 1'b0), mk(SDecode, 1'b1, 6'h02, 1'b0, 1'b0),
            mk(SJump, 1'b1, 6'h02, 1'b0, 1'b0), mk(SFetch, 1'b1, 6'h02, 1'b1, 1'b0),
            mk(SDecode, 1'b1, 6'h04, 1'b0, 1'b0), mk(SBranch, 1'b1, 6'h04, 1'b0, 1'b0),
            mk(SFetch, 1'b1, 6'h00, 1'b0, 1'b0)};
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({obs_ctl, obs_cnt, obs_ill} !== {e.ctl, e.cnt, e.ill}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got ctl=%b cnt=%0d ill=%b, want ctl=%b cnt=%0d ill=%b",
                 i, obs_ctl, obs_cnt, obs_ill, e.ctl, e.cnt, e.ill);
      end
      advance(seq[i]);
    end
  endtask

  task automatic test_sw_reset();
    stim_t seq[$];
    apply_reset();
    // Reset arrives with mem_ready high while the store is stalled: no count, enables drop.
    seq = '{mk(SFetch, 1'b1, 6'h00, 1'b1, 1'b0), mk(SDecode, 1'b1, 6'h02, 1'b0, 1'b0),
            mk(SJump, 1'b1, 6'h02, 1'b0, 1'b0), mk(SFetch, 1'b1, 6'h02, 1'b1, 1'b0),
            mk(SDecode, 1'b1, 6'h2b, 1'b0, 1'b0), mk(SMemAdr, 1'b1, 6'h2b, 1'b0, 1'b0),
            mk(SMemWr, 1'b1, 6'h2b, 1'b0, 1'b0), mk(SMemWr, 1'b1, 6'h2b, 1'b0, 1'b0),
            mk(SRst, 1'b0, 6'h2b, 1'b1, 1'b0), mk(SFetch, 1'b1, 6'h2b, 1'b0, 1'b0)};
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({obs_ctl, obs_cnt, obs_ill} !== {e.ctl, e.cnt, e.ill}) begin
        n_fail++;
        $display("FAIL sw_reset[%0d]: got ctl=%b cnt=%0d ill=%b, want ctl=%b cnt=%0d ill=%b",
                 i, obs_ctl, obs_cnt, obs_ill, e.ctl, e.cnt, e.ill);
      end
      advance(seq[i]);
    end
  endtask

  initial begin
    bus_m.opcode = '0;  bus_m.mem_ready = 1'b0;  bus_m.zero = 1'b0;
    bus_nb.opcode = '0; bus_nb.mem_ready = 1'b0; bus_nb.zero = 1'b0;
    bus_nt.opcode = '0; bus_nt.mem_ready = 1'b0; bus_nt.zero = 1'b0;
    test_reset();
    test_add();
    test_lw_stall();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_sw_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
